// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; the requester drives start/a/b through the
// master modport and the subtractor answers through the slave modport.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b, one bit per clock LSB first with a registered borrow.
// Define SERIAL_SUB_SIGNED_OVF_EN to get a signed overflow flag; otherwise overflow is tied to 0.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, acc_d;
    logic [WIDTH-1:0] diff_q;
    logic [CntW-1:0]  cnt_q;
    logic             br_q, br_d, borrow_q;
    logic             a0, b0, d;
    logic             load, last;

    assign a0   = a_sh_q[0];
    assign b0   = b_sh_q[0];
    assign d    = a0 ^ b0 ^ br_q;
    assign br_d = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    // Working result shifts in from the MSB so it lines up after WIDTH steps.
    if (WIDTH == 1) begin : g_acc_w1
        assign acc_d = d;
    end else begin : g_acc_wn
        assign acc_d = {d, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == CntLast) begin
                    last    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_sh_q <= bus.a;
                b_sh_q <= bus.b;
                acc_q  <= '0;
                br_q   <= 1'b0;
                cnt_q  <= '0;
            end else if (state_q == StRun) begin
                a_sh_q <= a_sh_q >> 1;
                b_sh_q <= b_sh_q >> 1;
                acc_q  <= acc_d;
                br_q   <= br_d;
                cnt_q  <= cnt_q + CntW'(1);
                if (last) begin
                    diff_q   <= acc_d;
                    borrow_q <= br_d;
                end
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_q;

    // On the last step a0/b0/d are the operand and result sign bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (a0 != b0) && (d != a0);
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.ready  = (state_q == StIdle) || (state_q == StDone);
    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule
